// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared definitions for the reorder buffer: instruction word layout, physical
// register tag, the {rd, T} packet exchanged with the map tables, the default
// buffer depth (`ROB_SZ) and the architectural zero register (`ZERO_REG).
// Ports: none (package).
// -----------------------------------------------------------------------------
`ifndef ROB_SZ
`define ROB_SZ 8
`endif
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif

package reorder_buffer_pkg;

    localparam int         ROB_SZ_DEF = `ROB_SZ;
    localparam logic [4:0] ZERO_REG   = `ZERO_REG;
    localparam int         PREG_W     = 6;

    // R-type view of the instruction; only rd is consumed by the buffer
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } r_type_t;

    typedef union packed {
        logic [31:0] raw;
        r_type_t     r;
    } INST;

    typedef struct packed {
        logic [PREG_W-1:0] reg_num;
    } PREG;

    typedef struct packed {
        logic [4:0] rd;
        PREG        T;
    } ROB_PACKET;

endpackage

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// Circular in-order retirement buffer. Dispatch writes {rd, T} at the tail,
// completion marks entries done, the head retires when complete (or completing
// in the same cycle). Optional squash support is compiled in with the macro
// ROB_UNDO_EN; without it undo/undo_index are present but ignored.
//
// Ports:
//   clock            in   rising-edge clock
//   reset            in   synchronous reset, active low
//   inst             in   dispatched instruction (destination in inst.r.rd)
//   write            in   dispatch request
//   finish           in   entry finish_index has completed
//   finish_index     in   index of the completed entry
//   free_reg         in   physical register allocated to the dispatch
//   undo             in   squash request
//   undo_index       in   youngest surviving entry after the squash
//   stall            out  combinational: buffer holds ROB_SZ entries
//   used_free_reg    out  free_reg consumed by the last accepted dispatch
//   update_free_list out  free_index valid
//   update_map_table out  rob_mt_packet valid
//   rob_mt_packet    out  {rd, T} of the last accepted dispatch
//   inst_index       out  entry index of the last accepted dispatch
//   update_arch_map  out  rob_am_packet valid
//   rob_am_packet    out  retired entry
//   free_index       out  T of the retired entry
//   full             out  previous-cycle write was rejected
// All outputs except stall are registered (one-cycle latency).
// -----------------------------------------------------------------------------
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter  int ROB_SZ = ROB_SZ_DEF,
    localparam int IDX_W  = $clog2(ROB_SZ)
) (
    input  logic             clock,
    input  logic             reset,
    input  INST              inst,
    input  logic             write,
    input  logic             finish,
    input  logic [IDX_W-1:0] finish_index,
    input  logic [4:0]       free_reg,
    input  logic             undo,
    input  logic [IDX_W-1:0] undo_index,
    output logic             stall,
    output logic             used_free_reg,
    output logic             update_free_list,
    output logic             update_map_table,
    output ROB_PACKET        rob_mt_packet,
    output logic [IDX_W-1:0] inst_index,
    output logic             update_arch_map,
    output ROB_PACKET        rob_am_packet,
    output PREG              free_index,
    output logic             full
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(ROB_SZ);

    ROB_PACKET         entry_r [ROB_SZ];
    logic [ROB_SZ-1:0] valid_r;
    logic [ROB_SZ-1:0] complete_r;
    logic [IDX_W-1:0]  head_r;
    logic [IDX_W-1:0]  tail_r;
    logic [IDX_W:0]    count_r;

    logic              undo_s;
    logic              retire_s;
    logic              accept_s;
    logic              reject_s;
    logic              rd_is_reg_s;
    ROB_PACKET         dispatch_pkt_s;
    logic [IDX_W-1:0]  span_s;
    logic [ROB_SZ-1:0] keep_s;
    logic [IDX_W:0]    undo_count_s;
    logic [IDX_W-1:0]  head_nxt_s;
    logic [IDX_W-1:0]  tail_nxt_s;
    logic [IDX_W:0]    count_nxt_s;

    // Only rd is taken from the instruction word
    logic unused_inst_s;
    assign unused_inst_s = ^{inst.raw[31:12], inst.raw[6:0]};

`ifdef ROB_UNDO_EN
    assign undo_s = undo;
`else
    assign undo_s = 1'b0;
    logic unused_undo_s;
    assign unused_undo_s = undo;
`endif

    assign stall = (count_r == FULL_CNT);

    // Retire/accept decisions, squash mask and next pointer/count values
    always_comb begin
        retire_s       = 1'b0;
        accept_s       = 1'b0;
        reject_s       = 1'b0;
        rd_is_reg_s    = (inst.r.rd != ZERO_REG);
        dispatch_pkt_s = '{rd: inst.r.rd, T: '{reg_num: PREG_W'(free_reg)}};
        span_s         = undo_index - head_r;
        keep_s         = '0;
        undo_count_s   = (IDX_W+1)'(span_s) + (IDX_W+1)'(1);

        // A head entry completing this very cycle retires without waiting
        if (valid_r[head_r] && (complete_r[head_r] ||
            (finish && (finish_index == head_r)))) begin
            retire_s = 1'b1;
        end else begin
            retire_s = 1'b0;
        end

        // Squash wins over dispatch; the dropped write is not a rejection
        if (undo_s) begin
            accept_s = 1'b0;
            reject_s = 1'b0;
        end else if (write && ((count_r < FULL_CNT) || retire_s)) begin
            accept_s = 1'b1;
            reject_s = 1'b0;
        end else begin
            accept_s = 1'b0;
            reject_s = write;
        end

        // Entries whose age (distance from head) is within the surviving span
        for (int i = 0; i < ROB_SZ; i++) begin
            keep_s[i] = ((IDX_W'(i) - head_r) <= span_s);
        end

        if (retire_s) begin
            head_nxt_s   = head_r + IDX_W'(1);
            undo_count_s = undo_count_s - (IDX_W+1)'(1);
        end else begin
            head_nxt_s   = head_r;
        end

        if (undo_s) begin
            tail_nxt_s  = undo_index + IDX_W'(1);
            count_nxt_s = undo_count_s;
        end else begin
            tail_nxt_s  = accept_s ? (tail_r + IDX_W'(1)) : tail_r;
            count_nxt_s = count_r + (IDX_W+1)'(accept_s) - (IDX_W+1)'(retire_s);
        end
    end

    // Buffer storage and pointers; later assignments take priority on overlap
    always_ff @(posedge clock) begin
        if (!reset) begin
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
            valid_r    <= '0;
            complete_r <= '0;
            for (int i = 0; i < ROB_SZ; i++) begin
                entry_r[i] <= '0;
            end
        end else begin
            if (finish) begin
                complete_r[finish_index] <= 1'b1;
            end
            if (undo_s) begin
                valid_r <= valid_r & keep_s;
            end
            if (retire_s) begin
                valid_r[head_r]    <= 1'b0;
                complete_r[head_r] <= 1'b0;
            end
            if (accept_s) begin
                entry_r[tail_r]    <= dispatch_pkt_s;
                valid_r[tail_r]    <= 1'b1;
                complete_r[tail_r] <= 1'b0;
            end
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Registered dispatch/retire/full reporting
    always_ff @(posedge clock) begin
        if (!reset) begin
            update_arch_map  <= 1'b0;
            update_free_list <= 1'b0;
            rob_am_packet    <= '0;
            free_index       <= '0;
            update_map_table <= 1'b0;
            used_free_reg    <= 1'b0;
            rob_mt_packet    <= '0;
            inst_index       <= '0;
            full             <= 1'b0;
        end else begin
            if (retire_s) begin
                update_arch_map  <= 1'b1;
                update_free_list <= 1'b1;
                rob_am_packet    <= entry_r[head_r];
                free_index       <= entry_r[head_r].T;
            end else begin
                update_arch_map  <= 1'b0;
                update_free_list <= 1'b0;
                rob_am_packet    <= '0;
                free_index       <= '0;
            end
            // Packet and index hold their last dispatch when nothing is accepted
            if (accept_s) begin
                inst_index       <= tail_r;
                rob_mt_packet    <= dispatch_pkt_s;
                update_map_table <= rd_is_reg_s;
                used_free_reg    <= rd_is_reg_s;
            end else begin
                update_map_table <= 1'b0;
                used_free_reg    <= 1'b0;
            end
            full <= reject_s;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
// Directed and randomized stimulus for reorder_buffer, checked against a
// queue-based reference model (oldest entry at the front).
// -----------------------------------------------------------------------------
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int SZ    = ROB_SZ_DEF;
    localparam int IDX_W = $clog2(SZ);

    logic             clock;
    logic             reset;
    INST              inst;
    logic             write;
    logic             finish;
    logic [IDX_W-1:0] finish_index;
    logic [4:0]       free_reg;
    logic             undo;
    logic [IDX_W-1:0] undo_index;
    logic             stall;
    logic             used_free_reg;
    logic             update_free_list;
    logic             update_map_table;
    ROB_PACKET        rob_mt_packet;
    logic [IDX_W-1:0] inst_index;
    logic             update_arch_map;
    ROB_PACKET        rob_am_packet;
    PREG              free_index;
    logic             full;

    reorder_buffer #(.ROB_SZ(SZ)) dut (
        .clock(clock), .reset(reset), .inst(inst), .write(write),
        .finish(finish), .finish_index(finish_index), .free_reg(free_reg),
        .undo(undo), .undo_index(undo_index), .stall(stall),
        .used_free_reg(used_free_reg), .update_free_list(update_free_list),
        .update_map_table(update_map_table), .rob_mt_packet(rob_mt_packet),
        .inst_index(inst_index), .update_arch_map(update_arch_map),
        .rob_am_packet(rob_am_packet), .free_index(free_index), .full(full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    typedef struct {
        logic [4:0] rd;
        logic [4:0] t;
        bit         done;
    } ent_t;
    ent_t q[$];
    int   head_m;
    logic e_uam, e_ufl, e_umt, e_ufr, e_full;
    logic [4:0] e_am_rd, e_am_t, e_mt_rd, e_mt_t;
    logic [IDX_W-1:0] e_idx;

    int total_cnt;
    int fail_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic rst, input logic wr, input logic [4:0] rd,
                         input logic [4:0] fr, input logic fin, input logic [IDX_W-1:0] fi,
                         input logic und, input logic [IDX_W-1:0] ui);
        int n, pos, keep, tail;
        bit retire, accept, und_en;
        ent_t e;
        if (!rst) begin
            q.delete();
            head_m = 0;
            {e_uam, e_ufl, e_umt, e_ufr, e_full} = '0;
            {e_am_rd, e_am_t, e_mt_rd, e_mt_t} = '0;
            e_idx = '0;
            return;
        end
`ifdef ROB_UNDO_EN
        und_en = und;
`else
        und_en = 1'b0;
`endif
        n      = q.size();
        tail   = (head_m + n) % SZ;
        retire = (n > 0) && (q[0].done || (fin && int'(fi) == head_m));
        if (fin) begin
            pos = (int'(fi) - head_m + SZ) % SZ;
            if (pos < n) q[pos].done = 1'b1;
        end
        accept = 1'b0;
        if (und_en) begin
            keep = ((int'(ui) - head_m + SZ) % SZ) + 1;
            while (q.size() > keep) void'(q.pop_back());
        end else begin
            accept = wr && ((n < SZ) || retire);
        end
        {e_uam, e_ufl, e_am_rd, e_am_t} = '0;
        if (retire) begin
            e = q.pop_front();
            e_uam = 1'b1; e_ufl = 1'b1; e_am_rd = e.rd; e_am_t = e.t;
            head_m = (head_m + 1) % SZ;
        end
        if (accept) begin
            e.rd = rd; e.t = fr; e.done = 1'b0;
            q.push_back(e);
            e_idx = IDX_W'(tail);
            e_mt_rd = rd; e_mt_t = fr;
            e_umt = (rd != ZERO_REG); e_ufr = (rd != ZERO_REG);
        end else begin
            e_umt = 1'b0; e_ufr = 1'b0;
        end
        e_full = wr && !accept && !und_en;
    endtask

    // Drive one cycle of inputs, advance the model, clock, then check every output
    task automatic step(input logic rst, input logic wr, input logic [4:0] rd,
                        input logic [4:0] fr, input logic fin, input logic [IDX_W-1:0] fi,
                        input logic und, input logic [IDX_W-1:0] ui);
        reset = rst; write = wr; inst = '0; inst.r.rd = rd; inst.r.opcode = 7'h33;
        free_reg = fr; finish = fin; finish_index = fi; undo = und; undo_index = ui;
        model(rst, wr, rd, fr, fin, fi, und, ui);
        @(posedge clock);
        #1;
        chk("update_arch_map",  64'(update_arch_map),  64'(e_uam));
        chk("update_free_list", 64'(update_free_list), 64'(e_ufl));
        chk("am_rd",            64'(rob_am_packet.rd), 64'(e_am_rd));
        chk("am_T",             64'(rob_am_packet.T.reg_num), 64'(e_am_t));
        chk("free_index",       64'(free_index.reg_num), 64'(e_am_t));
        chk("update_map_table", 64'(update_map_table), 64'(e_umt));
        chk("used_free_reg",    64'(used_free_reg),    64'(e_ufr));
        chk("mt_rd",            64'(rob_mt_packet.rd), 64'(e_mt_rd));
        chk("mt_T",             64'(rob_mt_packet.T.reg_num), 64'(e_mt_t));
        chk("inst_index",       64'(inst_index),       64'(e_idx));
        chk("full",             64'(full),             64'(e_full));
        chk("stall",            64'(stall),            64'(q.size() == SZ));
    endtask

    initial begin
        total_cnt = 0;
        fail_cnt  = 0;
        head_m    = 0;
        reset = 1'b0; write = 1'b0; inst = '0; free_reg = '0;
        finish = 1'b0; finish_index = '0; undo = 1'b0; undo_index = '0;
        #2;

        // Reset
        step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b1, 5'd4, 5'd4, 1'b0, '0, 1'b0, '0);
        chk("rst_inst_index", 64'(inst_index), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);

        // First dispatch rd=1, T=5
        step(1'b1, 1'b1, 5'd1, 5'd5, 1'b0, '0, 1'b0, '0);
        chk("d1_idx", 64'(inst_index), 64'd0);
        chk("d1_umt", 64'(update_map_table), 64'd1);
        chk("d1_ufr", 64'(used_free_reg), 64'd1);
        chk("d1_pkt", 64'({rob_mt_packet.rd, rob_mt_packet.T.reg_num}), 64'({5'd1, 6'd5}));
        chk("d1_uam", 64'(update_arch_map), 64'd0);
        chk("d1_full", 64'(full), 64'd0);

        // Zero-register destination
        step(1'b1, 1'b1, ZERO_REG, 5'd7, 1'b0, '0, 1'b0, '0);
        chk("z_umt", 64'(update_map_table), 64'd0);
        chk("z_ufr", 64'(used_free_reg), 64'd0);
        chk("z_T", 64'(rob_mt_packet.T.reg_num), 64'd7);
        chk("z_idx", 64'(inst_index), 64'd1);

        // Fill remaining entries
        for (int i = 2; i < SZ; i++) begin
            step(1'b1, 1'b1, 5'(i + 2), 5'(i + 10), 1'b0, '0, 1'b0, '0);
            chk("fill_idx", 64'(inst_index), 64'(i));
            chk("fill_full", 64'(full), 64'd0);
        end
        chk("fill_stall", 64'(stall), 64'd1);

        // Write into a full buffer without completion
        step(1'b1, 1'b1, 5'd9, 5'd9, 1'b0, '0, 1'b0, '0);
        chk("rej_full", 64'(full), 64'd1);
        chk("rej_umt", 64'(update_map_table), 64'd0);
        chk("rej_stall", 64'(stall), 64'd1);

        // Full buffer, head completes in the same cycle as a write
        step(1'b1, 1'b1, 5'd3, 5'd8, 1'b1, '0, 1'b0, '0);
        chk("byp_full", 64'(full), 64'd0);
        chk("byp_uam", 64'(update_arch_map), 64'd1);
        chk("byp_ufl", 64'(update_free_list), 64'd1);
        chk("byp_free", 64'(free_index.reg_num), 64'd5);
        chk("byp_idx", 64'(inst_index), 64'd0);
        chk("byp_pkt", 64'({rob_mt_packet.rd, rob_mt_packet.T.reg_num}), 64'({5'd3, 6'd8}));

        // Squash back to entry 1 with entries 0..4 live
        step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 5'(i + 1), 5'(i + 1), 1'b0, '0, 1'b0, '0);
        end
        step(1'b1, 1'b1, 5'd6, 5'd6, 1'b0, '0, 1'b1, IDX_W'(1));
        chk("undo_nofull", 64'(full), 64'd0);
        step(1'b1, 1'b1, 5'd7, 5'd7, 1'b0, '0, 1'b0, '0);
`ifdef ROB_UNDO_EN
        chk("undo_idx", 64'(inst_index), 64'd2);
`else
        chk("undo_ignored_idx", 64'(inst_index), 64'd6);
`endif

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            logic rst_v, wr_v, fin_v, und_v;
            logic [IDX_W-1:0] fi_v, ui_v;
            rst_v = ($urandom_range(63) != 0);
            wr_v  = ($urandom_range(9) < 6);
            fin_v = ($urandom_range(9) < 5);
            fi_v  = IDX_W'($urandom_range(SZ - 1));
            und_v = 1'b0;
            ui_v  = IDX_W'($urandom);
            if (q.size() > 0 && $urandom_range(9) == 0) begin
                und_v = 1'b1;
                ui_v  = IDX_W'((head_m + int'($urandom_range(q.size() - 1))) % SZ);
            end
            step(rst_v, wr_v, 5'($urandom_range(31)), 5'($urandom_range(31)),
                 fin_v, fi_v, und_v, ui_v);
        end

        $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
        $finish;
    end

endmodule
